// File: rtl/mips_regwrite_arbiter.sv
// mips_regwrite_arbiter
// Shares the single register-file write port between ALU writeback (req0)
// and memory-load writeback (req1). Round-robin grant, one registered write
// per cycle, plus read-after-write hazard flags for both decode read ports.
module mips_regwrite_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic              stall_rs,
  output logic              stall_rt,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              signal_reg_write,
  output logic              last_grant,
  output logic [CNT_W-1:0]  commit_count
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  // Registered write-port state
  logic [ADDR_W-1:0] write_reg_reg,  write_reg_next;
  logic [DATA_W-1:0] write_data_reg, write_data_next;
  logic              wr_en_reg,      wr_en_next;
  logic              last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]  count_reg,      count_next;

  // Arbitration results
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // Round-robin grant: on contention the requester that did not win last goes.
  // Grants are forced low during reset so nothing is accepted while held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_reg;
        grant1 = ~last_grant_reg;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;

  // Select the granted requester's payload for the write stage
  always_comb begin
    gnt_addr = req0_addr;
    gnt_data = req0_data;
    if (grant1) begin
      gnt_addr = req1_addr;
      gnt_data = req1_data;
    end
  end

  // Next write-port state: load on transfer, otherwise hold with enable low.
  // Writes to register 0 are accepted but never enabled nor counted.
  always_comb begin
    write_reg_next  = write_reg_reg;
    write_data_next = write_data_reg;
    last_grant_next = last_grant_reg;
    wr_en_next      = 1'b0;
    count_next      = count_reg;
    if (xfer) begin
      write_reg_next  = gnt_addr;
      write_data_next = gnt_data;
      last_grant_next = grant1;
      wr_en_next      = (gnt_addr != ZERO_ADDR);
    end
    if (wr_en_next) begin
      count_next = count_reg + CNT_ONE;
    end
  end

  // Write-port and arbitration state registers; reset drops any in-flight write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg_reg  <= '0;
      write_data_reg <= '0;
      wr_en_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      count_reg      <= '0;
    end else begin
      write_reg_reg  <= write_reg_next;
      write_data_reg <= write_data_next;
      wr_en_reg      <= wr_en_next;
      last_grant_reg <= last_grant_next;
      count_reg      <= count_next;
    end
  end

  assign write_reg        = write_reg_reg;
  assign write_data       = write_data_reg;
  assign signal_reg_write = wr_en_reg;
  assign last_grant       = last_grant_reg;
  assign commit_count     = count_reg;

  // Hazard detection: a read port stalls when its register is targeted by
  // either pending request or by the write currently on the register-file port.
  logic [ADDR_W-1:0] rd_addr [2];
  logic [1:0]        stall_vec;

  assign rd_addr[0] = read_reg_1;
  assign rd_addr[1] = read_reg_2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
    assign stall_vec[gi] = (rd_addr[gi] != ZERO_ADDR) &&
                           ((req0_valid && (req0_addr == rd_addr[gi])) ||
                            (req1_valid && (req1_addr == rd_addr[gi])) ||
                            (wr_en_reg  && (write_reg_reg == rd_addr[gi])));
  end

  assign stall_rs = stall_vec[0];
  assign stall_rt = stall_vec[1];

endmodule

// File: tb/tb_mips_regwrite_arbiter.sv
// Directed testbench for mips_regwrite_arbiter (counter narrowed to 2 bits
// so the wrap can be exercised in a few writes).
module tb_mips_regwrite_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst_n;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [ADDR_W-1:0] read_reg_1;
  logic [ADDR_W-1:0] read_reg_2;
  logic              stall_rs;
  logic              stall_rt;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              signal_reg_write;
  logic              last_grant;
  logic [CNT_W-1:0]  commit_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_cnt;

  mips_regwrite_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req0_valid       (req0_valid),
    .req0_addr        (req0_addr),
    .req0_data        (req0_data),
    .req0_ready       (req0_ready),
    .req1_valid       (req1_valid),
    .req1_addr        (req1_addr),
    .req1_data        (req1_data),
    .req1_ready       (req1_ready),
    .read_reg_1       (read_reg_1),
    .read_reg_2       (read_reg_2),
    .stall_rs         (stall_rs),
    .stall_rt         (stall_rt),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .signal_reg_write (signal_reg_write),
    .last_grant       (last_grant),
    .commit_count     (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and log the write port
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t we=%0b reg=%0d data=%h lg=%0b cnt=%0d", $time,
             signal_reg_write, write_reg, write_data, last_grant, commit_count);
  endtask

  task automatic test_reset();
    // Put something in flight, then hit reset between edges
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_1234;
    step();
    if (signal_reg_write !== 1'b1) begin n_err++; $display("FAIL pre_reset_we got=%0b want=1", signal_reg_write); end
    n_cmp++;
    #3;
    rst_n = 1'b0;
    #1;
    if (write_reg !== 5'd0) begin n_err++; $display("FAIL rst_write_reg got=%0d want=0", write_reg); end
    n_cmp++;
    if (write_data !== 32'h0) begin n_err++; $display("FAIL rst_write_data got=%h want=0", write_data); end
    n_cmp++;
    if (signal_reg_write !== 1'b0) begin n_err++; $display("FAIL rst_we got=%0b want=0", signal_reg_write); end
    n_cmp++;
    if (last_grant !== 1'b1) begin n_err++; $display("FAIL rst_last_grant got=%0b want=1", last_grant); end
    n_cmp++;
    if (commit_count !== 2'd0) begin n_err++; $display("FAIL rst_count got=%0d want=0", commit_count); end
    n_cmp++;
    if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_req0_ready got=%0b want=0", req0_ready); end
    n_cmp++;
    step();
    rst_n = 1'b1;
    exp_cnt = '0;
    req0_addr = 5'd2; req0_data = 32'hAAAA_AAAA;
    #1;
    if (req0_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready got=%0b want=1", req0_ready); end
    n_cmp++;
    step();
    req0_valid = 1'b0;
    exp_cnt++;
    if (signal_reg_write !== 1'b1 || write_reg !== 5'd2 || write_data !== 32'hAAAA_AAAA) begin
      n_err++;
      $display("FAIL first_write got we=%0b reg=%0d data=%h want we=1 reg=2 data=aaaaaaaa",
               signal_reg_write, write_reg, write_data);
    end
    n_cmp++;
    if (commit_count !== exp_cnt) begin n_err++; $display("FAIL first_count got=%0d want=%0d", commit_count, exp_cnt); end
    n_cmp++;
    step();
    if (signal_reg_write !== 1'b0 || write_reg !== 5'd2) begin
      n_err++;
      $display("FAIL idle_hold got we=%0b reg=%0d want we=0 reg=2", signal_reg_write, write_reg);
    end
    n_cmp++;
  endtask

  task automatic test_zero_reg();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h5555_5555;
    #1;
    if (req1_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready got=%0b want=1", req1_ready); end
    n_cmp++;
    step();
    req1_valid = 1'b0;
    if (last_grant !== 1'b1) begin n_err++; $display("FAIL zero_last_grant got=%0b want=1", last_grant); end
    n_cmp++;
    if (signal_reg_write !== 1'b0) begin n_err++; $display("FAIL zero_we got=%0b want=0", signal_reg_write); end
    n_cmp++;
    if (commit_count !== exp_cnt) begin n_err++; $display("FAIL zero_count got=%0d want=%0d", commit_count, exp_cnt); end
    n_cmp++;
    if (write_reg !== 5'd0 || write_data !== 32'h5555_5555) begin
      n_err++;
      $display("FAIL zero_port got reg=%0d data=%h want reg=0 data=55555555", write_reg, write_data);
    end
    n_cmp++;
  endtask

  task automatic test_contention();
    logic exp_g;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'd1;
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'd2;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 1);
      #1;
      if (req0_ready !== !exp_g || req1_ready !== exp_g) begin
        n_err++;
        $display("FAIL cont_ready[%0d] got r0=%0b r1=%0b want r0=%0b r1=%0b",
                 i, req0_ready, req1_ready, !exp_g, exp_g);
      end
      n_cmp++;
      step();
      exp_cnt++;
      if (signal_reg_write !== 1'b1 || last_grant !== exp_g ||
          write_reg !== (exp_g ? 5'd5 : 5'd4) || write_data !== (exp_g ? 32'd2 : 32'd1)) begin
        n_err++;
        $display("FAIL cont_port[%0d] got we=%0b lg=%0b reg=%0d data=%h want we=1 lg=%0b reg=%0d",
                 i, signal_reg_write, last_grant, write_reg, write_data, exp_g, exp_g ? 5 : 4);
      end
      n_cmp++;
      if (commit_count !== exp_cnt) begin n_err++; $display("FAIL cont_count[%0d] got=%0d want=%0d", i, commit_count, exp_cnt); end
      n_cmp++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    if (signal_reg_write !== 1'b0) begin n_err++; $display("FAIL cont_idle_we got=%0b want=0", signal_reg_write); end
    n_cmp++;
  endtask

  task automatic test_hazard();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h3333_0000;
    read_reg_1 = 5'd3; read_reg_2 = 5'd0;
    #1;
    if (stall_rs !== 1'b1 || stall_rt !== 1'b0) begin
      n_err++; $display("FAIL haz_pending got rs=%0b rt=%0b want rs=1 rt=0", stall_rs, stall_rt);
    end
    n_cmp++;
    step();
    req0_valid = 1'b0;
    exp_cnt++;
    #1;
    if (stall_rs !== 1'b1) begin n_err++; $display("FAIL haz_inflight got=%0b want=1", stall_rs); end
    n_cmp++;
    step();
    if (stall_rs !== 1'b0) begin n_err++; $display("FAIL haz_written got=%0b want=0", stall_rs); end
    n_cmp++;
    if (commit_count !== exp_cnt) begin n_err++; $display("FAIL haz_count got=%0d want=%0d", commit_count, exp_cnt); end
    n_cmp++;
    // Pending write to register 0 must not stall a read of register 0
    read_reg_1 = 5'd0; req0_valid = 1'b1; req0_addr = 5'd0;
    #1;
    if (stall_rs !== 1'b0) begin n_err++; $display("FAIL haz_zero got=%0b want=0", stall_rs); end
    n_cmp++;
    // Rt port sees a pending req1 write
    req0_valid = 1'b0;
    read_reg_2 = 5'd9; req1_valid = 1'b1; req1_addr = 5'd9;
    #1;
    if (stall_rt !== 1'b1 || stall_rs !== 1'b0) begin
      n_err++; $display("FAIL haz_rt got rs=%0b rt=%0b want rs=0 rt=1", stall_rs, stall_rt);
    end
    n_cmp++;
    req1_valid = 1'b0; read_reg_2 = 5'd0;
  endtask

  task automatic test_back_to_back();
    // req1 wins alone, so last_grant=1 and req0 wins the next contention
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
    step();
    exp_cnt++;
    req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'h88;
    req1_addr = 5'd9; req1_data = 32'h99;
    #1;
    if (last_grant !== 1'b1 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready got lg=%0b r0=%0b r1=%0b want lg=1 r0=1 r1=0", last_grant, req0_ready, req1_ready);
    end
    n_cmp++;
    step();
    exp_cnt++;
    req0_valid = 1'b0;
    if (write_reg !== 5'd8 || write_data !== 32'h88 || last_grant !== 1'b0) begin
      n_err++;
      $display("FAIL bp_req0_port got reg=%0d data=%h lg=%0b want reg=8 data=88 lg=0", write_reg, write_data, last_grant);
    end
    n_cmp++;
    #1;
    if (req1_ready !== 1'b1) begin n_err++; $display("FAIL bp_req1_ready got=%0b want=1", req1_ready); end
    n_cmp++;
    step();
    exp_cnt++;
    req1_valid = 1'b0;
    if (write_reg !== 5'd9 || write_data !== 32'h99 || last_grant !== 1'b1 || signal_reg_write !== 1'b1) begin
      n_err++;
      $display("FAIL bp_req1_port got reg=%0d data=%h lg=%0b we=%0b want reg=9 data=99 lg=1 we=1",
               write_reg, write_data, last_grant, signal_reg_write);
    end
    n_cmp++;
    if (commit_count !== exp_cnt) begin n_err++; $display("FAIL bp_count got=%0d want=%0d", commit_count, exp_cnt); end
    n_cmp++;
    step();
  endtask

  task automatic test_counter_wrap();
    logic [CNT_W-1:0] seq [5];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_addr = 5'(10 + i); req0_data = 32'(i);
      step();
      if (commit_count !== seq[i]) begin
        n_err++; $display("FAIL wrap_count[%0d] got=%0d want=%0d", i, commit_count, seq[i]);
      end
      n_cmp++;
    end
    req0_valid = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    read_reg_1 = '0; read_reg_2 = '0;
    exp_cnt = '0;
    #12;
    rst_n = 1'b1;
    step();
    test_reset();
    test_zero_reg();
    test_contention();
    test_hazard();
    test_back_to_back();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
